// File: rtl/ahb_mgr.sv
// ahb_mgr: AHB-Lite manager driving a subordinate from a command/beat interface.
// Issues SINGLE or INCR4 transfers with pipelined address/data phases, BUSY
// insertion while write data is missing, hready stalls and two-cycle error aborts.
// Optional build macro AHB_MGR_TIMEOUT_EN: abort with err_code 3 after
// TIMEOUT_CYCLES consecutive hready=0 cycles while a command is in flight.
module ahb_mgr #(
   parameter int unsigned ADDR_W         = 10,
   parameter int unsigned DATA_W         = 64,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              n_rst,
   // command interface
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [1:0]        cmd_size,
   input  logic              cmd_incr4,
   // write beats
   input  logic              wbeat_valid,
   output logic              wbeat_ready,
   input  logic [DATA_W-1:0] wbeat_data,
   // read beats and completion
   output logic              rbeat_valid,
   output logic [DATA_W-1:0] rbeat_data,
   output logic              rbeat_last,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   // AHB-Lite manager port
   output logic              hsel,
   output logic [ADDR_W-1:0] haddr,
   output logic [1:0]        htrans,
   output logic [1:0]        hsize,
   output logic [2:0]        hburst,
   output logic              hwrite,
   output logic [DATA_W-1:0] hwdata,
   input  logic              hready,
   input  logic              hresp,
   input  logic [DATA_W-1:0] hrdata
);

   localparam logic [1:0] HtIdle   = 2'b00;
   localparam logic [1:0] HtBusy   = 2'b01;
   localparam logic [1:0] HtNonseq = 2'b10;
   localparam logic [1:0] HtSeq    = 2'b11;

   localparam logic [1:0] ErrResp     = 2'd1;
   localparam logic [1:0] ErrBoundary = 2'd2;
   localparam logic [1:0] ErrTimeout  = 2'd3;

   typedef enum logic [2:0] {StIdle, StAddr, StXfer, StData, StErr} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [1:0]          size_q, size_d;
   logic                write_q, write_d;
   logic                incr4_q, incr4_d;
   logic [2:0]          issued_q, issued_d;   // address phases completed
   logic                pend_q, pend_d;       // address phase stalled, must be held
   logic                dp_q, dp_d;           // a data phase is in progress
   logic                dp_last_q, dp_last_d;
   logic                dp_write_q, dp_write_d;
   logic [DATA_W-1:0]   hwdata_q, hwdata_d;
   logic                rbeat_valid_q, rbeat_valid_d;
   logic [DATA_W-1:0]   rbeat_data_q, rbeat_data_d;
   logic                rbeat_last_q, rbeat_last_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [1:0]          err_code_q, err_code_d;

   logic [ADDR_W:0]     burst_bytes;
   logic [ADDR_W:0]     end_addr;
   logic [ADDR_W-1:0]   size_mask;
   logic                cmd_bad;
   logic                beat_ok;
   logic                last_issue;
   logic                hresp_abort;
   logic                dp_complete;
   logic                to_hit;

   // An INCR4 may end exactly at the top of the space but not past it.
   assign burst_bytes = (ADDR_W+1)'(4) << cmd_size;
   assign end_addr    = {1'b0, cmd_addr} + burst_bytes;
   assign size_mask   = (ADDR_W'(1) << cmd_size) - ADDR_W'(1);
   assign cmd_bad     = (|(cmd_addr & size_mask)) ||
                        (cmd_incr4 && (end_addr > (ADDR_W+1)'(1 << ADDR_W)));

   // A held (stalled) address phase is re-presented even if write data vanished.
   assign beat_ok     = !write_q || wbeat_valid || pend_q;
   assign last_issue  = incr4_q ? (issued_q == 3'd3) : 1'b1;
   assign hresp_abort = dp_q && hresp;
   assign dp_complete = dp_q && hready && !hresp && (state_q != StErr);

`ifdef AHB_MGR_TIMEOUT_EN
   localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
   logic [ToW-1:0] to_q, to_d;

   // Count consecutive stalled cycles while a command is in flight.
   always_comb begin
      to_d   = (state_q == StIdle || hready) ? '0 : to_q + ToW'(1);
      to_hit = (state_q != StIdle) && !hready && (to_q == ToW'(TIMEOUT_CYCLES - 1));
   end

   // Stall counter register.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         to_q <= '0;
      end else begin
         to_q <= to_d;
      end
   end
`else
   logic unused_timeout_cycles;
   assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
   assign to_hit = 1'b0;
`endif

   // Next-state, AHB drive and handshake decode.
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      size_d        = size_q;
      write_d       = write_q;
      incr4_d       = incr4_q;
      issued_d      = issued_q;
      pend_d        = 1'b0;
      dp_d          = dp_q;
      dp_last_d     = dp_last_q;
      dp_write_d    = dp_write_q;
      hwdata_d      = hwdata_q;
      rbeat_valid_d = 1'b0;
      rbeat_last_d  = 1'b0;
      rbeat_data_d  = rbeat_data_q;
      done_d        = 1'b0;
      err_d         = 1'b0;
      err_code_d    = 2'd0;
      cmd_ready     = 1'b0;
      wbeat_ready   = 1'b0;
      hsel          = 1'b0;
      haddr         = '0;
      htrans        = HtIdle;
      hsize         = 2'd0;
      hburst        = 3'b000;
      hwrite        = 1'b0;

      if (dp_complete && !dp_write_q) begin
         rbeat_valid_d = 1'b1;
         rbeat_last_d  = dp_last_q;
         rbeat_data_d  = hrdata;
      end

      case (state_q)
         StIdle: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (cmd_bad) begin
                  err_d      = 1'b1;
                  err_code_d = ErrBoundary;
               end else begin
                  addr_d   = cmd_addr;
                  size_d   = cmd_size;
                  write_d  = cmd_write;
                  incr4_d  = cmd_incr4;
                  issued_d = 3'd0;
                  state_d  = StAddr;
               end
            end
         end
         StAddr, StXfer: begin
            hsel   = 1'b1;
            haddr  = addr_q;
            hsize  = size_q;
            hburst = incr4_q ? 3'b011 : 3'b000;
            hwrite = write_q;
            if (hresp_abort) begin
               // Cancel the pending address in the first error cycle.
               htrans = HtIdle;
               if (hready) begin
                  err_d      = 1'b1;
                  err_code_d = ErrResp;
                  dp_d       = 1'b0;
                  state_d    = StIdle;
               end else begin
                  state_d = StErr;
               end
            end else begin
               if (beat_ok) begin
                  htrans = (state_q == StAddr) ? HtNonseq : HtSeq;
               end else begin
                  htrans = (state_q == StAddr) ? HtIdle : HtBusy;
               end
               if (hready) begin
                  dp_d       = beat_ok;
                  dp_last_d  = last_issue;
                  dp_write_d = write_q;
                  if (beat_ok) begin
                     wbeat_ready = write_q;
                     if (write_q) begin
                        hwdata_d = wbeat_data;
                     end
                     addr_d   = addr_q + (ADDR_W'(1) << size_q);
                     issued_d = issued_q + 3'd1;
                     state_d  = last_issue ? StData : StXfer;
                  end
               end else begin
                  pend_d = beat_ok;
               end
            end
         end
         StData: begin
            if (hresp_abort) begin
               if (hready) begin
                  err_d      = 1'b1;
                  err_code_d = ErrResp;
                  dp_d       = 1'b0;
                  state_d    = StIdle;
               end else begin
                  state_d = StErr;
               end
            end else if (dp_complete) begin
               done_d  = 1'b1;
               dp_d    = 1'b0;
               state_d = StIdle;
            end
         end
         StErr: begin
            if (hready) begin
               err_d      = 1'b1;
               err_code_d = ErrResp;
               dp_d       = 1'b0;
               state_d    = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (to_hit) begin
         hsel          = 1'b0;
         htrans        = HtIdle;
         wbeat_ready   = 1'b0;
         rbeat_valid_d = 1'b0;
         rbeat_last_d  = 1'b0;
         done_d        = 1'b0;
         err_d         = 1'b1;
         err_code_d    = ErrTimeout;
         dp_d          = 1'b0;
         pend_d        = 1'b0;
         state_d       = StIdle;
      end
   end

   // State and pipeline registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q       <= StIdle;
         addr_q        <= '0;
         size_q        <= 2'd0;
         write_q       <= 1'b0;
         incr4_q       <= 1'b0;
         issued_q      <= 3'd0;
         pend_q        <= 1'b0;
         dp_q          <= 1'b0;
         dp_last_q     <= 1'b0;
         dp_write_q    <= 1'b0;
         hwdata_q      <= '0;
         rbeat_valid_q <= 1'b0;
         rbeat_data_q  <= '0;
         rbeat_last_q  <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         err_code_q    <= 2'd0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         size_q        <= size_d;
         write_q       <= write_d;
         incr4_q       <= incr4_d;
         issued_q      <= issued_d;
         pend_q        <= pend_d;
         dp_q          <= dp_d;
         dp_last_q     <= dp_last_d;
         dp_write_q    <= dp_write_d;
         hwdata_q      <= hwdata_d;
         rbeat_valid_q <= rbeat_valid_d;
         rbeat_data_q  <= rbeat_data_d;
         rbeat_last_q  <= rbeat_last_d;
         done_q        <= done_d;
         err_q         <= err_d;
         err_code_q    <= err_code_d;
      end
   end

   assign hwdata      = hwdata_q;
   assign rbeat_valid = rbeat_valid_q;
   assign rbeat_data  = rbeat_data_q;
   assign rbeat_last  = rbeat_last_q;
   assign done        = done_q;
   assign err         = err_q;
   assign err_code    = err_code_q;

endmodule

// File: tb/tb_ahb_mgr.sv
// tb_ahb_mgr: directed cycle-by-cycle bench for ahb_mgr with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_ahb_mgr;

   logic        clk;
   logic        n_rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [9:0]  cmd_addr;
   logic [1:0]  cmd_size;
   logic        cmd_incr4;
   logic        wbeat_valid;
   logic        wbeat_ready;
   logic [63:0] wbeat_data;
   logic        rbeat_valid;
   logic [63:0] rbeat_data;
   logic        rbeat_last;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic        hsel;
   logic [9:0]  haddr;
   logic [1:0]  htrans;
   logic [1:0]  hsize;
   logic [2:0]  hburst;
   logic        hwrite;
   logic [63:0] hwdata;
   logic        hready;
   logic        hresp;
   logic [63:0] hrdata;

   int n_chk;
   int n_pass;

   ahb_mgr dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_size    (cmd_size),
      .cmd_incr4   (cmd_incr4),
      .wbeat_valid (wbeat_valid),
      .wbeat_ready (wbeat_ready),
      .wbeat_data  (wbeat_data),
      .rbeat_valid (rbeat_valid),
      .rbeat_data  (rbeat_data),
      .rbeat_last  (rbeat_last),
      .done        (done),
      .err         (err),
      .err_code    (err_code),
      .hsel        (hsel),
      .haddr       (haddr),
      .htrans      (htrans),
      .hsize       (hsize),
      .hburst      (hburst),
      .hwrite      (hwrite),
      .hwdata      (hwdata),
      .hready      (hready),
      .hresp       (hresp),
      .hrdata      (hrdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Present a command for one cycle with the given write-beat inputs.
   task automatic issue(input bit wr, input logic [9:0] a, input logic [1:0] sz, input bit i4,
                        input bit wv, input logic [63:0] wd);
      @(negedge clk);
      cmd_valid   = 1'b1;
      cmd_write   = wr;
      cmd_addr    = a;
      cmd_size    = sz;
      cmd_incr4   = i4;
      wbeat_valid = wv;
      wbeat_data  = wd;
      hready      = 1'b1;
      hresp       = 1'b0;
      #1;
   endtask

   // One bus cycle with no command.
   task automatic cyc(input bit wv, input logic [63:0] wd, input bit hr, input bit hs,
                      input logic [63:0] rd);
      @(negedge clk);
      cmd_valid   = 1'b0;
      wbeat_valid = wv;
      wbeat_data  = wd;
      hready      = hr;
      hresp       = hs;
      hrdata      = rd;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] d [4];
      logic [63:0] r [4];
      int nwr;
      int nrb;
      int bad;

      n_chk = 0;
      n_pass = 0;
      n_rst = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr = '0;
      cmd_size = '0;
      cmd_incr4 = 1'b0;
      wbeat_valid = 1'b0;
      wbeat_data = '0;
      hready = 1'b1;
      hresp = 1'b0;
      hrdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst_htrans", 64'(htrans), 64'd0);
      check("rst_hsel", 64'(hsel), 64'd0);
      check("rst_haddr", 64'(haddr), 64'd0);
      check("rst_hwdata", hwdata, 64'd0);
      check("rst_flags", 64'({done, err, err_code, rbeat_valid, wbeat_ready}), 64'd0);
      n_rst = 1'b1;

      // SINGLE write, byte at 0x022
      issue(1'b1, 10'h022, 2'd0, 1'b0, 1'b1, 64'h0000_AB00_0000_0000);
      check("t1_accept", 64'(cmd_ready), 64'd1);
      cyc(1'b1, 64'h0000_AB00_0000_0000, 1'b1, 1'b0, 64'd0);
      check("t1_htrans", 64'(htrans), 64'd2);
      check("t1_haddr", 64'(haddr), 64'h022);
      check("t1_ctrl", 64'({hsel, hburst, hwrite, hsize}), 64'({1'b1, 3'b000, 1'b1, 2'd0}));
      check("t1_wready", 64'(wbeat_ready), 64'd1);
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      check("t1_idle", 64'(htrans), 64'd0);
      check("t1_hwdata", hwdata, 64'h0000_AB00_0000_0000);
      check("t1_done_early", 64'(done), 64'd0);
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      check("t1_done", 64'(done), 64'd1);
      check("t1_ready_again", 64'(cmd_ready), 64'd1);
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      check("t1_done_pulse", 64'(done), 64'd0);

      // INCR4 write, dword, all beats available
      d[0] = 64'h1111_0000_0000_0001; d[1] = 64'h2222_0000_0000_0002;
      d[2] = 64'h3333_0000_0000_0003; d[3] = 64'h4444_0000_0000_0004;
      nwr = 0;
      issue(1'b1, 10'h000, 2'd3, 1'b1, 1'b1, d[0]);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, d[i], 1'b1, 1'b0, 64'd0);
         check("t2_htrans", 64'(htrans), (i == 0) ? 64'd2 : 64'd3);
         check("t2_haddr", 64'(haddr), 64'(i * 8));
         if (i > 0) check("t2_hwdata", hwdata, d[i-1]);
         if (wbeat_ready) nwr++;
      end
      check("t2_hburst", 64'(hburst), 64'd3);
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      check("t2_tail_idle", 64'(htrans), 64'd0);
      check("t2_hwdata4", hwdata, d[3]);
      if (wbeat_ready) nwr++;
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      check("t2_done", 64'(done), 64'd1);
      check("t2_nwr", 64'(nwr), 64'd4);

      // INCR4 write with two missing-data cycles before beat 3
      d[0] = 64'hA0; d[1] = 64'hA1; d[2] = 64'hA2; d[3] = 64'hA3;
      issue(1'b1, 10'h000, 2'd3, 1'b1, 1'b1, d[0]);
      cyc(1'b1, d[0], 1'b1, 1'b0, 64'd0);
      check("t3_nonseq", 64'(htrans), 64'd2);
      cyc(1'b1, d[1], 1'b1, 1'b0, 64'd0);
      check("t3_seq1", 64'({htrans, haddr}), 64'({2'd3, 10'h008}));
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
         check("t3_busy", 64'({htrans, haddr}), 64'({2'd1, 10'h010}));
         check("t3_busy_wready", 64'(wbeat_ready), 64'd0);
         check("t3_busy_hwdata", hwdata, d[1]);
      end
      cyc(1'b1, d[2], 1'b1, 1'b0, 64'd0);
      check("t3_resume", 64'({htrans, haddr, wbeat_ready}), 64'({2'd3, 10'h010, 1'b1}));
      cyc(1'b1, d[3], 1'b1, 1'b0, 64'd0);
      check("t3_seq3", 64'({htrans, haddr}), 64'({2'd3, 10'h018}));
      check("t3_hwdata3", hwdata, d[2]);
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      check("t3_hwdata4", hwdata, d[3]);
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      check("t3_done", 64'(done), 64'd1);

      // INCR4 read, hready low for 3 cycles on beat 2
      r[0] = 64'hDEAD_0000_0000_0000; r[1] = 64'hDEAD_0000_0000_0001;
      r[2] = 64'hDEAD_0000_0000_0002; r[3] = 64'hDEAD_0000_0000_0003;
      nrb = 0;
      issue(1'b0, 10'h000, 2'd3, 1'b1, 1'b0, 64'd0);
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      check("t4_nonseq", 64'({htrans, haddr, hwrite}), 64'({2'd2, 10'h000, 1'b0}));
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
         check("t4_held", 64'({htrans, haddr, hburst}), 64'({2'd3, 10'h008, 3'b011}));
         check("t4_no_rbeat", 64'(rbeat_valid), 64'd0);
      end
      cyc(1'b0, 64'd0, 1'b1, 1'b0, r[0]);
      check("t4_seq_rel", 64'({htrans, haddr}), 64'({2'd3, 10'h008}));
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 64'd0, 1'b1, 1'b0, (i < 3) ? r[i+1] : 64'd0);
         check("t4_rvalid", 64'(rbeat_valid), 64'd1);
         check("t4_rdata", rbeat_data, r[i]);
         check("t4_rlast", 64'(rbeat_last), (i == 3) ? 64'd1 : 64'd0);
         if (rbeat_valid) nrb++;
      end
      check("t4_done", 64'(done), 64'd1);
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      if (rbeat_valid) nrb++;
      check("t4_nrb", 64'(nrb), 64'd4);

      // INCR4 read at 0x018 with two-cycle error on beat 1
      issue(1'b0, 10'h018, 2'd3, 1'b1, 1'b0, 64'd0);
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      check("t5_nonseq", 64'({htrans, haddr}), 64'({2'd2, 10'h018}));
      cyc(1'b0, 64'd0, 1'b0, 1'b1, 64'd0);
      check("t5_cancel", 64'(htrans), 64'd0);
      cyc(1'b0, 64'd0, 1'b1, 1'b1, 64'd0);
      check("t5_err_wait", 64'({htrans, hsel, err}), 64'd0);
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      check("t5_err", 64'({err, err_code}), 64'({1'b1, 2'd1}));
      check("t5_no_rbeat", 64'({rbeat_valid, done}), 64'd0);
      check("t5_idle", 64'(cmd_ready), 64'd1);
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      check("t5_err_pulse", 64'(err), 64'd0);

      // Direct hresp=1/hready=1 on a write burst: abort, no further wbeat taken
      issue(1'b1, 10'h100, 2'd2, 1'b1, 1'b1, 64'h55);
      cyc(1'b1, 64'h55, 1'b1, 1'b0, 64'd0);
      check("t6_nonseq", 64'({htrans, haddr, hsize}), 64'({2'd2, 10'h100, 2'd2}));
      cyc(1'b1, 64'h66, 1'b1, 1'b1, 64'd0);
      check("t6_abort", 64'({htrans, wbeat_ready}), 64'd0);
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      check("t6_err", 64'({err, err_code, cmd_ready}), 64'({1'b1, 2'd1, 1'b1}));

      // Boundary errors and exact-fit burst
      issue(1'b0, 10'h3F0, 2'd3, 1'b1, 1'b0, 64'd0);
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      check("t7_overflow", 64'({htrans, hsel, err, err_code}), 64'({2'd0, 1'b0, 1'b1, 2'd2}));
      issue(1'b1, 10'h003, 2'd1, 1'b0, 1'b1, 64'h77);
      cyc(1'b1, 64'h77, 1'b1, 1'b0, 64'd0);
      check("t7_misalign", 64'({htrans, wbeat_ready, err, err_code}),
            64'({2'd0, 1'b0, 1'b1, 2'd2}));
      issue(1'b0, 10'h3E0, 2'd3, 1'b1, 1'b0, 64'd0);
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      check("t7_fit", 64'({htrans, haddr, err}), 64'({2'd2, 10'h3E0, 1'b0}));
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      check("t7_fit_last", 64'({htrans, haddr}), 64'({2'd3, 10'h3F8}));
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      check("t7_fit_done", 64'(done), 64'd1);

      // Long hready stall on a SINGLE read
      bad = 0;
      issue(1'b0, 10'h040, 2'd3, 1'b0, 1'b0, 64'd0);
`ifdef AHB_MGR_TIMEOUT_EN
      for (int i = 0; i < 63; i++) begin
         cyc(1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
         if (err || htrans != 2'd2) bad++;
      end
      check("t8_pre_timeout", 64'(bad), 64'd0);
      cyc(1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
      check("t8_force_idle", 64'({htrans, hsel}), 64'd0);
      cyc(1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
      check("t8_timeout", 64'({err, err_code}), 64'({1'b1, 2'd3}));
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      check("t8_after", 64'({err, cmd_ready}), 64'({1'b0, 1'b1}));
`else
      for (int i = 0; i < 70; i++) begin
         cyc(1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
         if (err || htrans != 2'd2 || haddr != 10'h040) bad++;
      end
      check("t8_hold", 64'(bad), 64'd0);
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'hCAFE);
      check("t8_data_idle", 64'(htrans), 64'd0);
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      check("t8_rbeat", 64'({rbeat_valid, rbeat_last, done, err}), 64'({4'b1110}));
      check("t8_rdata", rbeat_data, 64'hCAFE);
`endif

      // Reset mid-burst abandons the transfer
      issue(1'b1, 10'h000, 2'd3, 1'b1, 1'b1, 64'h99);
      cyc(1'b1, 64'h99, 1'b1, 1'b0, 64'd0);
      cyc(1'b1, 64'h9A, 1'b1, 1'b0, 64'd0);
      check("t9_mid", 64'(htrans), 64'd3);
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      cyc(1'b1, 64'h9B, 1'b1, 1'b0, 64'd0);
      check("t9_rst_bus", 64'({htrans, hsel, wbeat_ready}), 64'd0);
      check("t9_rst_hwdata", hwdata, 64'd0);
      check("t9_rst_ready", 64'(cmd_ready), 64'd1);
      n_rst = 1'b1;
      cyc(1'b0, 64'd0, 1'b1, 1'b0, 64'd0);
      check("t9_no_done", 64'({done, err}), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
